// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with interrupt request
//
// Purpose:
//   Device-side countdown timer on the CPU/device bridge. Software programs a
//   reload value (PRESET) and a control word (CTRL); the timer loads PRESET,
//   counts down to zero, sets a pending flag and requests an interrupt when
//   CTRL.IM is set. One-shot mode disables itself on expiry; auto-reload mode
//   restarts from PRESET after a single-cycle interrupt pulse.
//
// Register map (addr[3:2]):
//   0 CTRL   rw  [0] EN, [2:1] MODE (01 auto-reload, otherwise one-shot), [3] IM
//   1 PRESET rw  reload value
//   2 COUNT  ro  current count
//   3 reserved, reads 0
//
// Ports:
//   clk    in   1   system clock, all state updates on rising edge
//   reset  in   1   synchronous, active-high
//   we     in   1   device write enable from the bridge
//   addr   in   32  byte address; addr[31:4] decodes the instance, addr[3:2] the register
//   wdata  in   32  store data
//   rdata  out  32  combinational read data of the register selected by addr[3:2]
//   irq    out  1   interrupt request (CTRL.IM & pending)

module timer_dev #(
  parameter logic [31:0] DEV_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam logic [1:0] MODE_AUTO  = 2'b01;

  // Only the four implemented CTRL bits are stored; the rest read as zero.
  logic [3:0]  ctrl_q,    ctrl_d;
  logic [31:0] preset_q,  preset_d;
  logic [31:0] count_q,   count_d;
  logic        pending_q, pending_d;
  logic [1:0]  state_q,   state_d;

  logic        dev_hit;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        ctrl_en;
  logic        ctrl_auto;

  // Byte lane bits carry no meaning for word registers.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign dev_hit   = (addr[31:4] == DEV_BASE[31:4]);
  assign wr_ctrl   = we & dev_hit & (addr[3:2] == REG_CTRL);
  assign wr_preset = we & dev_hit & (addr[3:2] == REG_PRESET);

  assign ctrl_en   = ctrl_q[0];
  assign ctrl_auto = (ctrl_q[2:1] == MODE_AUTO);

  always_comb begin
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    state_d   = state_q;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_en) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end

      ST_CNT: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Also covers PRESET=0: count never goes below zero.
          count_d   = 32'd0;
          pending_d = 1'b1;
          state_d   = ST_INT;
        end
      end

      ST_INT: begin
        if (ctrl_auto) begin
          // Auto-reload: pending lives for exactly the one cycle spent in INT.
          pending_d = 1'b0;
          state_d   = ST_LOAD;
        end else begin
          // One-shot: drop EN, keep pending until software acknowledges it.
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Software writes are applied last so they override any FSM update to
    // CTRL or pending in the same cycle.
    if (wr_ctrl) begin
      ctrl_d    = wdata[3:0];
      pending_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d  = wdata;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= 4'd0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      state_q   <= state_d;
    end
  end

  // Read path is decoded from addr[3:2] only; reads have no side effects.
  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      REG_CTRL:   rdata = {28'd0, ctrl_q};
      REG_PRESET: rdata = preset_q;
      REG_COUNT:  rdata = count_q;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = ctrl_q[3] & pending_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - self-checking bench for timer_dev

module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  timer_dev #(.DEV_BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: register values plus a description of what the timer
  // is doing (waiting to reload, running down, or just expired).
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_pend;
  logic        m_reload_next;
  logic        m_running;
  logic        m_just_expired;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    logic enabled, autoreload, mine;
    enabled    = m_ctrl[0];
    autoreload = (m_ctrl[2:1] == 2'b01);
    mine       = w && (a[31:4] == BASE[31:4]);
    if (rst) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_pend = 1'b0;
      m_reload_next = 1'b0; m_running = 1'b0; m_just_expired = 1'b0;
    end else begin
      if (m_just_expired) begin
        m_just_expired = 1'b0;
        if (autoreload) begin
          m_pend = 1'b0;
          m_reload_next = 1'b1;
        end else begin
          m_ctrl[0] = 1'b0;
        end
      end else if (m_reload_next) begin
        m_reload_next = 1'b0;
        m_count = m_preset;
        m_running = 1'b1;
      end else if (m_running) begin
        if (!enabled) m_running = 1'b0;
        else if (m_count > 1) m_count = m_count - 1;
        else begin
          m_count = 0;
          m_pend = 1'b1;
          m_running = 1'b0;
          m_just_expired = 1'b1;
        end
      end else if (enabled) begin
        m_reload_next = 1'b1;
      end
      if (mine && a[3:2] == 2'd0) begin m_ctrl = d[3:0]; m_pend = 1'b0; end
      if (mine && a[3:2] == 2'd1) begin m_preset = d;    m_pend = 1'b0; end
    end
  endtask

  // One bus cycle: drive, compare combinational outputs, clock, advance model.
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic rst_now;
    we = w; addr = a; wdata = d;
    #1;
    chk("rdata", rdata, m_read(a));
    chk("irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_pend});
    rst_now = reset;
    @(posedge clk);
    model_edge(rst_now, w, a, d);
    #1;
  endtask

  int pulses;

  initial begin
    reset = 1'b1; we = 1'b0; addr = BASE; wdata = 32'd0;
    repeat (2) begin
      @(posedge clk);
      model_edge(1'b1, 1'b0, BASE, 32'd0);
      #1;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = BASE + 32'(i * 4);
      #1;
      chk("rst_rdata", rdata, 32'd0);
    end
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // One-shot with interrupt enabled.
    cyc(1'b1, BASE + 32'h4, 32'd5);
    cyc(1'b1, BASE, 32'h9);
    repeat (7) cyc(1'b0, BASE + 32'h8, 32'd0);
    chk("s2_count0", rdata, 32'd0);
    chk("s2_irq", {31'd0, irq}, 32'd1);
    cyc(1'b0, BASE, 32'd0);
    chk("s2_ctrl", rdata, 32'h8);
    repeat (3) cyc(1'b0, BASE, 32'd0);
    chk("s2_irq_held", {31'd0, irq}, 32'd1);
    cyc(1'b1, BASE, 32'h0);
    chk("s2_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload: one-cycle pulse every PRESET+2 cycles.
    cyc(1'b1, BASE + 32'h4, 32'd3);
    cyc(1'b1, BASE, 32'hB);
    pulses = 0;
    repeat (16) begin
      cyc(1'b0, BASE + 32'h8, 32'd0);
      if (irq) pulses++;
    end
    chk("s3_pulses", 32'(pulses), 32'd3);
    cyc(1'b1, BASE, 32'h0);
    cyc(1'b0, BASE, 32'd0);

    // Interrupt masked: expiry happens, irq stays low.
    cyc(1'b1, BASE + 32'h4, 32'd3);
    cyc(1'b1, BASE, 32'h1);
    pulses = 0;
    repeat (10) begin
      cyc(1'b0, BASE + 32'h8, 32'd0);
      if (irq) pulses++;
    end
    chk("s4_pulses", 32'(pulses), 32'd0);
    chk("s4_count", rdata, 32'd0);

    // EN cleared mid-count freezes COUNT; re-enable reloads PRESET.
    cyc(1'b1, BASE, 32'h0);
    cyc(1'b1, BASE + 32'h4, 32'd10);
    cyc(1'b1, BASE, 32'h1);
    repeat (8) cyc(1'b0, BASE + 32'h8, 32'd0);
    chk("s5_count4", rdata, 32'd4);
    cyc(1'b1, BASE, 32'h0);
    repeat (3) cyc(1'b0, BASE + 32'h8, 32'd0);
    chk("s5_hold", rdata, 32'd3);
    cyc(1'b1, BASE, 32'h1);
    cyc(1'b0, BASE + 32'h8, 32'd0);
    chk("s5_not_yet", rdata, 32'd3);
    cyc(1'b0, BASE + 32'h8, 32'd0);
    chk("s5_reload", rdata, 32'd10);

    // Writes to read-only, reserved and foreign addresses are dropped.
    cyc(1'b1, BASE, 32'h0);
    cyc(1'b1, BASE + 32'h8,  32'h1234);
    cyc(1'b1, BASE + 32'hC,  32'h1234);
    cyc(1'b1, BASE + 32'h14, 32'h1234);
    addr = BASE + 32'hC; #1;
    chk("s6_reserved", rdata, 32'd0);
    addr = BASE; #1;
    chk("s6_ctrl", rdata, 32'd0);
    addr = BASE + 32'h8; #1;
    chk("s6_count", rdata, 32'd9);

    // Randomized traffic against the model, including mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 99));
      a = BASE | {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      if (r < 3) begin
        reset = 1'b1;
        cyc(1'b0, a, 32'd0);
        reset = 1'b0;
      end else if (r < 13) begin
        cyc(1'b1, BASE, $urandom);
      end else if (r < 19) begin
        cyc(1'b1, BASE + 32'h4, 32'($urandom_range(0, 7)));
      end else if (r < 23) begin
        cyc(1'b1, a ^ (32'd1 << $urandom_range(4, 31)), $urandom);
      end else if (r < 27) begin
        cyc(1'b1, BASE | {28'd0, 1'b1, 1'($urandom_range(0, 1)), 2'b00}, $urandom);
      end else begin
        cyc(1'b0, a, $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
